// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared state encodings, SDRAM widths and default address window for the ADC capture path
package adc_capture_pkg;
  localparam int ADDR_W = 22;
  localparam int DATA_W = 16;
  localparam logic [ADDR_W-1:0] DEF_ADDR_START = 22'h000000;
  localparam logic [ADDR_W-1:0] DEF_ADDR_LAST = 22'h3FFFFF;
  typedef enum logic [1:0] {C_IDLE, C_RUN, C_FLUSH} ctrl_state_t;
  typedef enum logic [1:0] {D_IDLE, D_REQ, D_WAIT} drain_state_t;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: single-clock FIFO of 2^DEPTH_LOG2 samples; head word shown on rd_data while not empty
// Ports: clk, rst_n (sync active-low), push/wr_data, pop/rd_data, full, empty, level (occupancy)
module sample_fifo
  import adc_capture_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  pop,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);
  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = level[DEPTH_LOG2];
  assign empty = level == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_pop) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      level <= level + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
    end
endmodule

// File: rtl/adc_sdram_writer.sv
// adc_sdram_writer: buffers ADC samples in a FIFO and drains them as single-word SDRAM write requests
// Ports: Clk, Reset_N (sync active-low); SampleIn/SampleValid stream in; Arm/Abort/Ring control;
//   Capturing/Done/Overflow/FifoLevel/DropCount status; SdramData/Addr/Req/WnR out, SdramBusy/Ack in.
// Build option DROP_COUNTER_EN: when defined DropCount counts dropped samples, otherwise it is tied to 0.
module adc_sdram_writer
  import adc_capture_pkg::*;
#(
  parameter int                FIFO_DEPTH_LOG2 = 4,
  parameter logic [ADDR_W-1:0] ADDR_START      = DEF_ADDR_START,
  parameter logic [ADDR_W-1:0] ADDR_LAST       = DEF_ADDR_LAST
) (
  input  logic                       Clk,
  input  logic                       Reset_N,
  input  logic [DATA_W-1:0]          SampleIn,
  input  logic                       SampleValid,
  input  logic                       Arm,
  input  logic                       Abort,
  input  logic                       Ring,
  output logic                       Capturing,
  output logic                       Done,
  output logic                       Overflow,
  output logic [FIFO_DEPTH_LOG2:0]   FifoLevel,
  output logic [DATA_W-1:0]          SdramData,
  output logic [ADDR_W-1:0]          SdramAddr,
  output logic                       SdramReq,
  output logic                       SdramWnR,
  input  logic                       SdramBusy,
  input  logic                       SdramAck,
  output logic [15:0]                DropCount
);
  localparam logic [ADDR_W:0] CAP_WORDS = {1'b0, ADDR_LAST} - {1'b0, ADDR_START} + (ADDR_W+1)'(1);
  ctrl_state_t cstate;
  drain_state_t dstate;
  logic ring_mode, full, empty, arm_go, accept, push, drop, pop, last_sample, flushed;
  logic [ADDR_W:0] count;
  logic [DATA_W-1:0] head;
  logic [ADDR_W-1:0] next_addr;
  sample_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
    .clk(Clk), .rst_n(Reset_N), .push(push), .wr_data(SampleIn), .pop(pop),
    .rd_data(head), .full(full), .empty(empty), .level(FifoLevel)
  );
  assign SdramWnR = 1'b1;
  assign arm_go = cstate == C_IDLE && Arm;
  // a sample coinciding with Abort is not taken: Abort stops acceptance immediately
  assign accept = cstate == C_RUN && SampleValid && !Abort;
  // full is judged on the pre-pop level, so a same-cycle pop never rescues an arriving sample
  assign push = accept && !full;
  assign drop = accept && full;
  assign pop = dstate == D_IDLE && !empty && !SdramBusy && !SdramAck;
  assign last_sample = push && !ring_mode && count + (ADDR_W+1)'(1) == CAP_WORDS;
  assign flushed = empty && dstate == D_IDLE && !SdramBusy;
  assign next_addr = SdramAddr == ADDR_LAST ? ADDR_START : SdramAddr + ADDR_W'(1);
  always_ff @(posedge Clk)
    if (!Reset_N) begin
      cstate <= C_IDLE;
      ring_mode <= 1'b0;
      count <= '0;
      Capturing <= 1'b0;
      Done <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      if (drop) Overflow <= 1'b1;
      if (push) count <= count + (ADDR_W+1)'(1);
      case (cstate)
        C_IDLE: if (Arm) begin
          ring_mode <= Ring;
          Done <= 1'b0;
          Overflow <= 1'b0;
          count <= '0;
          Capturing <= 1'b1;
          cstate <= C_RUN;
        end
        C_RUN: if (Abort || last_sample) begin
          Capturing <= 1'b0;
          cstate <= C_FLUSH;
        end
        C_FLUSH: if (flushed) begin
          Done <= 1'b1;
          cstate <= C_IDLE;
        end
        default: cstate <= C_IDLE;
      endcase
    end
  always_ff @(posedge Clk)
    if (!Reset_N) begin
      dstate <= D_IDLE;
      SdramReq <= 1'b0;
      SdramData <= '0;
      SdramAddr <= ADDR_START;
    end else begin
      if (arm_go) SdramAddr <= ADDR_START;
      case (dstate)
        D_IDLE: if (pop) begin
          SdramData <= head;
          SdramReq <= 1'b1;
          dstate <= D_REQ;
        end
        D_REQ: if (SdramAck) begin
          SdramReq <= 1'b0;
          SdramAddr <= next_addr;
          dstate <= D_WAIT;
        end
        D_WAIT: if (!SdramBusy) dstate <= D_IDLE;
        default: dstate <= D_IDLE;
      endcase
    end
`ifdef DROP_COUNTER_EN
  always_ff @(posedge Clk)
    if (!Reset_N || arm_go) DropCount <= '0;
    else if (drop && DropCount != 16'hFFFF) DropCount <= DropCount + 16'd1;
`else
  assign DropCount = '0;
`endif
endmodule

// File: tb/tb_adc_sdram_writer.sv
// tb_adc_sdram_writer: self-checking bench with an SDRAM controller responder and an address/data write model
module tb_adc_sdram_writer;
  localparam int DL = 2;
  localparam int NW = 8;
  localparam logic [21:0] A0 = 22'd0;
  localparam logic [21:0] AL = 22'd7;
  logic Clk = 0, Reset_N = 0;
  logic [15:0] SampleIn = 0;
  logic SampleValid = 0, Arm = 0, Abort = 0, Ring = 0;
  logic Capturing, Done, Overflow, SdramReq, SdramWnR;
  logic [DL:0] FifoLevel;
  logic [15:0] SdramData, DropCount;
  logic [21:0] SdramAddr;
  logic SdramBusy = 0, SdramAck = 0;
  int n_chk = 0, n_fail = 0;
  int ack_dly = 1, tail = 0;
  bit force_busy = 0;
  typedef struct {logic [21:0] addr; logic [15:0] data;} wr_t;
  typedef struct {bit ring; int nsamp; int gap; int ack; int tail; bit abort; int exp_n;} vec_t;
  wr_t wlog[$], exp_q[$];
  vec_t vecs[6];
  vec_t rv;

  adc_sdram_writer #(.FIFO_DEPTH_LOG2(DL), .ADDR_START(A0), .ADDR_LAST(AL)) dut (
    .Clk(Clk), .Reset_N(Reset_N), .SampleIn(SampleIn), .SampleValid(SampleValid),
    .Arm(Arm), .Abort(Abort), .Ring(Ring), .Capturing(Capturing), .Done(Done),
    .Overflow(Overflow), .FifoLevel(FifoLevel), .SdramData(SdramData), .SdramAddr(SdramAddr),
    .SdramReq(SdramReq), .SdramWnR(SdramWnR), .SdramBusy(SdramBusy), .SdramAck(SdramAck),
    .DropCount(DropCount)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // controller stand-in: takes Req, Acks after ack_dly cycles, keeps Busy for tail cycles more
  initial begin
    int ph, cnt;
    logic [21:0] a;
    logic [15:0] d;
    ph = 0;
    cnt = 0;
    a = '0;
    d = '0;
    forever begin
      @(negedge Clk);
      SdramAck = 0;
      if (!Reset_N) begin
        ph = 0;
        SdramBusy = 0;
      end else case (ph)
        0: if (SdramReq) begin
          SdramBusy = 1; a = SdramAddr; d = SdramData; cnt = ack_dly - 1; ph = 1;
        end else SdramBusy = force_busy;
        1: begin
          chk("req_hold", SdramReq, 1);
          chk("addr_hold", SdramAddr, a);
          chk("data_hold", SdramData, d);
          if (cnt == 0) begin
            SdramAck = 1; wlog.push_back('{a, d}); cnt = tail; ph = 2;
          end else cnt--;
        end
        2: begin
          chk("req_drop", SdramReq, 0);
          if (cnt == 0) begin SdramBusy = 0; ph = 0; end
          else begin cnt--; ph = 3; end
        end
        default: if (cnt == 0) begin SdramBusy = 0; ph = 0; end else cnt--;
      endcase
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge Clk);
  endtask

  task automatic pulse_arm(input bit r);
    Arm = 1; Ring = r; tick(); Arm = 0;
  endtask

  task automatic send(input logic [15:0] v);
    SampleValid = 1; SampleIn = v; tick(); SampleValid = 0;
  endtask

  task automatic do_abort(input string nm);
    Abort = 1; tick(); Abort = 0;
    chk({nm, "_abort_cap"}, Capturing, 0);
  endtask

  task automatic wait_done(input string nm);
    int t = 0;
    while (!Done && t < 3000) begin tick(); t++; end
    chk({nm, "_done"}, Done, 1);
  endtask

  task automatic cmp_writes(input string nm);
    chk({nm, "_nwrites"}, wlog.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
      chk({nm, "_addr"}, wlog[i].addr, exp_q[i].addr);
      chk({nm, "_data"}, wlog[i].data, exp_q[i].data);
    end
    wlog.delete();
    exp_q.delete();
  endtask

  // model: the k-th captured sample lands at ADDR_START + k mod window size
  task automatic expect_write(input int k, input logic [15:0] s);
    exp_q.push_back('{A0 + 22'(k % NW), s});
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    logic [15:0] s;
    ack_dly = v.ack;
    tail = v.tail;
    pulse_arm(v.ring);
    chk({nm, "_cap"}, Capturing, 1);
    chk({nm, "_done_clr"}, Done, 0);
    chk({nm, "_drop_clr"}, DropCount, 0);
    for (int i = 0; i < v.nsamp; i++) begin
      s = 16'($urandom);
      if (i < v.exp_n) expect_write(i, s);
      send(s);
      if (!v.ring && i == NW - 1) chk({nm, "_cap_fall"}, Capturing, 0);
      tick(v.gap - 1 + int'($urandom_range(0, 2)));
    end
    if (v.abort) do_abort(nm);
    wait_done(nm);
    chk({nm, "_ovf"}, Overflow, 0);
    chk({nm, "_level"}, FifoLevel, 0);
    chk({nm, "_cap_end"}, Capturing, 0);
    cmp_writes(nm);
  endtask

  initial begin
    int t;
    vecs[0] = '{0, 8, 4, 1, 0, 0, 8};
    vecs[1] = '{0, 11, 6, 1, 0, 0, 8};
    vecs[2] = '{1, 6, 6, 1, 0, 1, 6};
    vecs[3] = '{1, 10, 6, 1, 0, 1, 10};
    vecs[4] = '{0, 3, 12, 5, 2, 1, 3};
    vecs[5] = '{1, 13, 10, 2, 1, 1, 13};
    tick(3);
    chk("rst_cap", Capturing, 0);
    chk("rst_done", Done, 0);
    chk("rst_ovf", Overflow, 0);
    chk("rst_level", FifoLevel, 0);
    chk("rst_req", SdramReq, 0);
    chk("rst_data", SdramData, 0);
    chk("rst_addr", SdramAddr, A0);
    chk("rst_wnr", SdramWnR, 1);
    chk("rst_drop", DropCount, 0);
    Reset_N = 1;
    tick(2);
    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // overflow: controller held busy so nothing drains during a 10-cycle burst
    ack_dly = 1; tail = 0; force_busy = 1;
    tick();
    pulse_arm(0);
    for (int i = 0; i < 10; i++) begin
      SampleValid = 1; SampleIn = 16'(16'h100 + i);
      if (i < 4) expect_write(i, 16'(16'h100 + i));
      tick();
    end
    SampleValid = 0;
    chk("ovf_level", FifoLevel, 4);
    chk("ovf_flag", Overflow, 1);
    chk("ovf_noreq", SdramReq, 0);
`ifdef DROP_COUNTER_EN
    chk("ovf_drops", DropCount, 6);
`else
    chk("ovf_drops", DropCount, 0);
`endif
    do_abort("ovf");
    force_busy = 0;
    wait_done("ovf");
    chk("ovf_sticky", Overflow, 1);
    cmp_writes("ovf");

    for (int r = 0; r < 3; r++) begin
      rv.ring = 1; rv.nsamp = int'($urandom_range(5, 20)); rv.gap = 10;
      rv.ack = int'($urandom_range(1, 3)); rv.tail = int'($urandom_range(0, 2));
      rv.abort = 1; rv.exp_n = rv.nsamp;
      run_vec(rv, $sformatf("rnd%0d", r));
    end

    // Arm while running must not restart capture or reset the address
    ack_dly = 1; tail = 0;
    pulse_arm(1);
    for (int i = 0; i < 3; i++) begin expect_write(i, 16'(16'h300 + i)); send(16'(16'h300 + i)); tick(8); end
    pulse_arm(0);
    chk("rearm_cap", Capturing, 1);
    chk("rearm_addr", SdramAddr, 3);
    for (int i = 3; i < 5; i++) begin expect_write(i, 16'(16'h300 + i)); send(16'(16'h300 + i)); tick(8); end
    do_abort("rearm");
    wait_done("rearm");
    cmp_writes("rearm");

    // reset in the middle of a pending request
    pulse_arm(1);
    for (int i = 0; i < 4; i++) send(16'(16'h200 + i));
    t = 0;
    while (wlog.size() < 2 && t < 200) begin tick(); t++; end
    tick();
    while (!SdramReq && t < 200) begin tick(); t++; end
    chk("mid_req", SdramReq, 1);
    chk("mid_addr", SdramAddr, 2);
    Reset_N = 0;
    tick();
    chk("mid_rst_req", SdramReq, 0);
    chk("mid_rst_level", FifoLevel, 0);
    chk("mid_rst_cap", Capturing, 0);
    chk("mid_rst_addr", SdramAddr, A0);
    tick();
    Reset_N = 1;
    tick();
    wlog.delete();
    exp_q.delete();
    rv = '{1, 3, 8, 1, 0, 1, 3};
    run_vec(rv, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_sdram_writer.md
# adc_sdram_writer

Capture stage that sits directly upstream of the SDRAM interface controller. Accepts a stream of 16-bit ADC samples, buffers them in a small FIFO, and drains them as sequential single-word write requests on the controller's Req/WnR/Ack/Busy handshake. Supports single-shot capture, which stops at the last address, and ring capture, which wraps around.

## Interface
- FIFO_DEPTH_LOG2, 4: FIFO holds 2^FIFO_DEPTH_LOG2 samples.
- ADDR_START, 22'h000000: first SDRAM word address written.
- ADDR_LAST, 22'h3FFFFF: last SDRAM word address written. Must be ≥ ADDR_START.
- Clk  in  1  single clock, all logic on rising edge.
- Reset_N  in  1  reset, synchronous, active-low.
- SampleIn  in  16  ADC sample.
- SampleValid  in  1  SampleIn valid this cycle; no back-pressure.
- Arm  in  1  start-capture pulse; honoured only when idle.
- Abort  in  1  stop accepting samples; FIFO still drains.
- Ring  in  1  sampled at Arm: 0 = single-shot, 1 = ring/wrap.
- Capturing  out  1  samples are being accepted.
- Done  out  1  capture finished and all words written; sticky until next Arm.
- Overflow  out  1  sticky: at least one sample dropped on a full FIFO.
- FifoLevel  out  FIFO_DEPTH_LOG2+1  current FIFO occupancy.
- SdramData  out  16  write data to controller DataIn.
- SdramAddr  out  22  word address to controller Address.
- SdramReq  out  1  request to controller.
- SdramWnR  out  1  constant 1 (write only).
- SdramBusy  in  1  controller Busy.
- SdramAck  in  1  controller Ack, registered one-cycle pulse.

## Operation
- Reset values: Capturing = 0, Done = 0, Overflow = 0, FifoLevel = 0, SdramReq = 0, SdramData = 0, SdramAddr = ADDR_START, SdramWnR = 1. FIFO is emptied and both FSMs go to idle.
- Control FSM states are C_IDLE, C_RUN, C_FLUSH.
  - C_IDLE: on Arm, latch Ring, clear Done/Overflow/sample count, set the drain address to ADDR_START, go to C_RUN.
  - C_RUN: push each SampleValid sample. Leave for C_FLUSH on Abort, or in single-shot mode when the pushed-sample count reaches ADDR_LAST−ADDR_START+1. Dropped samples do not count.
  - C_FLUSH: wait until the FIFO is empty and the drain FSM is in D_IDLE with SdramBusy = 0. Then set Done = 1 and go to C_IDLE.
  - Arm outside C_IDLE is ignored. Abort in C_IDLE is ignored.
- Drain FSM states are D_IDLE, D_REQ, D_WAIT.
  - D_IDLE: if the FIFO is non-empty, SdramBusy = 0 and SdramAck = 0, pop the head into SdramData and go to D_REQ.
  - D_REQ: SdramReq = 1. SdramData and SdramAddr are held stable until SdramAck = 1. Then SdramReq = 0, advance the address, go to D_WAIT.
  - D_WAIT: return to D_IDLE when SdramBusy = 0.
- Address advance: after ADDR_LAST the next address is ADDR_START. In ring mode the wrap overwrites the oldest data. In single-shot mode the wrap never triggers because the count limit stops capture first.
- FIFO full is evaluated before any pop in the same cycle. A sample arriving while full is dropped even if a pop also occurs that cycle, and Overflow is set.
- Push and pop in the same cycle on a non-full FIFO leave FifoLevel unchanged.
- Reset_N low mid-transfer drops SdramReq on the next edge and discards FIFO contents. The downstream controller is reset by its own Reset.

## Timing
- Sample pushed at edge t is visible in FifoLevel after t. If drain is idle, SdramReq rises after edge t+1 at the earliest.
- SdramReq stays high through the cycle SdramAck is sampled high and falls on the following edge.
- Minimum 3 cycles per written word against the current controller (REQ, Ack, Busy release). Sustained SampleValid faster than that overflows the FIFO by design.
- Done asserts on the edge after the flush condition holds. Capturing falls on the edge after the terminating sample or Abort.

## Configuration
- DROP_COUNTER_EN defined: a DropCount [15:0] output is present. It counts samples dropped while full, saturates at 16'hFFFF, and is cleared on Arm and on reset.
- Not defined: the DropCount port is present but tied to 0, and no counter logic is built. Overflow behaves the same in both builds.

## Structure
- Package adc_capture_pkg holds:
  - control and drain state encodings;
  - the SDRAM address width (22) and data width (16) constants;
  - the default ADDR_START/ADDR_LAST values.
- Sub-module sample_fifo: synchronous single-clock FIFO with push/pop/full/empty/level, parameterised by FIFO_DEPTH_LOG2.
- Control FSM, drain FSM and address counter live in the top module.

## Test plan
- Single-shot, ADDR_START = 0, ADDR_LAST = 7, 8 samples 16'h0001..16'h0008 one every 4 cycles, Ack 1 cycle after Req → 8 writes at addresses 0..7 with matching data, Done = 1, Overflow = 0.
- Ring, ADDR_LAST = 3, 6 samples A..F → writes to addresses 0,1,2,3,0,1. Abort then leads to Done after the last Ack.
- FIFO_DEPTH_LOG2 = 2, SampleValid high for 10 consecutive cycles, Busy stretched → exactly 4+k samples written, Overflow = 1, DropCount equals the dropped count when DROP_COUNTER_EN is defined.
- Ack delayed 5 cycles → SdramReq, SdramData and SdramAddr stable for all 5 cycles, and one write per Ack.
- Reset_N low while SdramReq = 1 → SdramReq = 0, FifoLevel = 0, Capturing = 0 after the next edge. Arm afterwards restarts at ADDR_START.
- Arm during C_RUN → ignored, with no address reset.
